// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: datapath width,
// ALU op codes and sequencer states.
package alu_pkg;

   localparam int unsigned WIDTH = 32;

   localparam logic [3:0] OP_MOV = 4'd0;
   localparam logic [3:0] OP_NOT = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on a tie the
// port that did not win last time is granted.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      if (valid[0] && (!valid[1] || last_grant)) begin
         grant[0] = 1'b1;
      end else if (valid[1]) begin
         grant[1] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: arbitrates,
// runs the operation from registered operands and returns the result.
module alu_share_ctrl #(
   parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic             rsp1_err,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   import alu_pkg::*;

   state_t           state;
   state_t           state_nxt;
   logic             last_grant;
   logic             port_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             err_q;
   logic [1:0]       grant;
   logic             accept;
   logic             rsp_done;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign accept   = (state == IDLE) && (grant != 2'b00);
   assign rsp_done = (state == RESP) && (port_q ? rsp1_ready : rsp0_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is gated by reset_n so nothing looks acceptable while reset is held.
   always_comb begin
      req0_ready = reset_n && (state == IDLE) && grant[0];
      req1_ready = reset_n && (state == IDLE) && grant[1];
      rsp0_valid = (state == RESP) && !port_q;
      rsp1_valid = (state == RESP) && port_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
         port_q     <= 1'b0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            port_q     <= grant[1];
            last_grant <= grant[1];
            op_q       <= grant[1] ? req1_op : req0_op;
            a_q        <= grant[1] ? req1_a  : req0_a;
            b_q        <= grant[1] ? req1_b  : req0_b;
         end
         if (state == EXEC) begin
            result_q <= alu_out;
            zero_q   <= alu_zero;
            err_q    <= op_q[3];
         end
      end
   end

   assign alu_ctrl    = op_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign rsp0_result = result_q;
   assign rsp0_zero   = zero_q;
   assign rsp0_err    = err_q;
   assign rsp1_result = result_q;
   assign rsp1_zero   = zero_q;
   assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU and a
// transaction-level reference for arbitration, latency and results.
module tb_alu_share_ctrl;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic         rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [W-1:0] rsp0_result, rsp1_result;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic         alu_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero)
   );

   function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         4'd0:    return a;
         4'd1:    return ~a;
         4'd2:    return a + b;
         4'd3:    return a - b;
         4'd4:    return a | b;
         4'd5:    return a & b;
         4'd6:    return a ^ b;
         4'd7:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      alu_out  = ref_alu(alu_ctrl, alu_a, alu_b);
      alu_zero = (alu_a == alu_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (p == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic rand_req(input int p);
      logic [W-1:0] a;
      a = $urandom;
      set_req(p, 1'b1, 4'($urandom), a, ($urandom_range(0, 3) == 0) ? a : W'($urandom));
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Returns one step after the accepting clock edge, i.e. at the start of EXEC.
   task automatic wait_grant(input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
            ok = 1'b1;
            tick();
            return;
         end
      end
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      repeat (6) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rand_req(0);
      rand_req(1);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
      end
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, rsp0_err, rsp1_err} !== 6'b0 ||
          rsp0_result !== '0 || rsp1_result !== '0) begin
         errors++;
         $display("FAIL reset_rsp: valid %b%b result %h %h want all zero",
                  rsp0_valid, rsp1_valid, rsp0_result, rsp1_result);
      end
      checks++;
      if (alu_ctrl !== 4'd0 || alu_a !== '0 || alu_b !== '0) begin
         errors++;
         $display("FAIL reset_alu: ctrl %h a %h b %h want 0 0 0", alu_ctrl, alu_a, alu_b);
      end
      apply_reset();
   endtask

   task automatic test_single_add();
      bit ok;
      set_req(0, 1'b1, 4'd2, 32'd5, 32'd7);
      rsp0_ready = 1'b1;
      wait_grant(0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL add_grant: no handshake within bound");
      end
      req0_valid = 1'b0;
      req0_a = $urandom;
      req0_op = 4'($urandom);
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || alu_ctrl !== 4'd2 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
         errors++;
         $display("FAIL add_exec: rsp0_valid %b ctrl %h a %h b %h want 0 2 5 7",
                  rsp0_valid, alu_ctrl, alu_a, alu_b);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_rsp: valid %b result %h zero %b err %b want 1 0000000c 0 0",
                  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err);
      end
      checks++;
      if (rsp1_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_port1: rsp1_valid %b want 0", rsp1_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_release: rsp0_valid %b want 0", rsp0_valid);
      end
      drain();
   endtask

   task automatic test_simultaneous();
      bit ok;
      apply_reset();
      set_req(0, 1'b1, 4'd3, 32'd10, 32'd10);
      set_req(1, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      wait_grant(0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sim_first: port0 not granted first");
      end
      req0_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero, rsp0_err} !==
          {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sim_rsp0: valid %b%b result %h zero %b err %b want 10 00000000 1 0",
                  rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero, rsp0_err);
      end
      set_req(0, 1'b1, 4'd0, 32'h55, 32'h0);
      wait_grant(1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sim_second: port1 not granted second");
      end
      req1_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp1_result, rsp1_zero, rsp1_err} !==
          {1'b1, 1'b0, 32'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sim_rsp1: valid %b%b result %h zero %b err %b want 10 00000001 0 0",
                  rsp1_valid, rsp0_valid, rsp1_result, rsp1_zero, rsp1_err);
      end
      rand_req(1);
      wait_grant(0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sim_third: port0 not granted on second tie");
      end
      drain();
   endtask

   task automatic test_backpressure();
      bit ok;
      set_req(1, 1'b1, 4'd6, 32'h0000_F0F0, 32'h0000_0FF0);
      rsp1_ready = 1'b0;
      wait_grant(1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_grant: port1 not granted");
      end
      req1_valid = 1'b0;
      rand_req(0);
      @(negedge clk);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp1_valid, rsp1_result, req0_ready, rsp0_valid} !== {1'b1, 32'h0000_FF00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: rsp1_valid %b result %h req0_ready %b rsp0_valid %b want 1 0000ff00 0 0",
                     i, rsp1_valid, rsp1_result, req0_ready, rsp0_valid);
         end
         tick();
      end
      rsp1_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({rsp1_valid, req0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_after: rsp1_valid %b req0_ready %b want 0 1", rsp1_valid, req0_ready);
      end
      tick();
      drain();
   endtask

   task automatic test_illegal();
      bit ok;
      set_req(0, 1'b1, 4'd9, 32'd3, 32'd3);
      rsp0_ready = 1'b1;
      wait_grant(0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL illegal_grant: no handshake within bound");
      end
      req0_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL illegal_rsp: valid %b result %h zero %b err %b want 1 00000000 1 1",
                  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err);
      end
      drain();
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      bit seen;
      set_req(0, 1'b1, 4'd2, 32'd1, 32'd2);
      rsp0_ready = 1'b1;
      wait_grant(0, ok);
      req0_valid = 1'b0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp1_valid, req0_ready, alu_ctrl} !== 7'b0 || alu_a !== '0 || alu_b !== '0) begin
         errors++;
         $display("FAIL rst_mid_now: valid %b%b ctrl %h a %h b %h want 00 0 0 0",
                  rsp0_valid, rsp1_valid, alu_ctrl, alu_a, alu_b);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen || !ok) begin
         errors++;
         $display("FAIL rst_mid_drop: stale response %b grant %b want 0 1", seen, ok);
      end
      set_req(0, 1'b1, 4'd0, 32'h1234, W'($urandom));
      wait_grant(0, ok);
      req0_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp0_result, rsp0_err} !== {1'b1, 32'h1234, 1'b0} || !ok) begin
         errors++;
         $display("FAIL rst_mid_mov: valid %b result %h err %b want 1 00001234 0",
                  rsp0_valid, rsp0_result, rsp0_err);
      end
      drain();
   endtask

   task automatic test_starvation();
      int n;
      int cyc;
      int g;
      apply_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      rand_req(0);
      n = 0;
      cyc = 0;
      while (n < 8 && cyc < 200) begin
         @(negedge clk);
         g = -1;
         if (req0_ready || req1_ready) begin
            g = req1_ready ? 1 : 0;
            checks++;
            if (g != n % 2 || (req0_ready && req1_ready)) begin
               errors++;
               $display("FAIL starve_grant[%0d]: ready %b%b want port %0d", n, req1_ready, req0_ready, n % 2);
            end
            n++;
         end
         tick();
         cyc++;
         if (g >= 0) rand_req(g);
         if (cyc == 2) rand_req(1);
      end
      checks++;
      if (n < 8) begin
         errors++;
         $display("FAIL starve_count: got %0d grants want 8", n);
      end
      drain();
   endtask

   task automatic test_random();
      int last;
      int w;
      int stall;
      logic [3:0] op;
      logic [W-1:0] a, b, exp_r, got_r;
      logic exp_z, exp_e, got_z, got_e;
      apply_reset();
      last = 1;
      for (int n = 0; n < 30; n++) begin
         if (!req0_valid && $urandom_range(0, 1) == 1) rand_req(0);
         if (!req1_valid && $urandom_range(0, 1) == 1) rand_req(1);
         if (!req0_valid && !req1_valid) rand_req($urandom_range(0, 1));
         @(negedge clk);
         w = (req0_valid && req1_valid) ? 1 - last : (req1_valid ? 1 : 0);
         checks++;
         if ({req1_ready, req0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rand_grant[%0d]: ready %b%b want port %0d", n, req1_ready, req0_ready, w);
         end
         last = w;
         op = (w == 1) ? req1_op : req0_op;
         a  = (w == 1) ? req1_a  : req0_a;
         b  = (w == 1) ? req1_b  : req0_b;
         exp_r = ref_alu(op, a, b);
         exp_z = (a == b);
         exp_e = op[3];
         tick();
         set_req(w, 1'b0, 4'($urandom), W'($urandom), W'($urandom));
         @(negedge clk);
         checks++;
         if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0 ||
             alu_ctrl !== op || alu_a !== a || alu_b !== b) begin
            errors++;
            $display("FAIL rand_exec[%0d]: ctrl %h a %h b %h want %h %h %h", n, alu_ctrl, alu_a, alu_b, op, a, b);
         end
         stall = $urandom_range(0, 3);
         for (int c = 0; c < 8; c++) begin
            tick();
            if (w == 1) begin
               rsp1_ready = (stall == 0);
               rsp0_ready = 1'($urandom);
            end else begin
               rsp0_ready = (stall == 0);
               rsp1_ready = 1'($urandom);
            end
            @(negedge clk);
            got_r = (w == 1) ? rsp1_result : rsp0_result;
            got_z = (w == 1) ? rsp1_zero   : rsp0_zero;
            got_e = (w == 1) ? rsp1_err    : rsp0_err;
            checks++;
            if ({rsp1_valid, rsp0_valid} !== ((w == 1) ? 2'b10 : 2'b01) ||
                {req1_ready, req0_ready} !== 2'b00 ||
                got_r !== exp_r || got_z !== exp_z || got_e !== exp_e) begin
               errors++;
               $display("FAIL rand_rsp[%0d]: valid %b%b result %h zero %b err %b want port %0d %h %b %b",
                        n, rsp1_valid, rsp0_valid, got_r, got_z, got_e, w, exp_r, exp_z, exp_e);
            end
            if (stall == 0) break;
            stall--;
         end
         tick();
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_add();
      test_simultaneous();
      test_backpressure();
      test_illegal();
      test_reset_mid_op();
      test_starvation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-port arbiter and sequencer sharing the single combinational ALU between two requesters (e.g. execute stage and address/branch unit). Accepts one operation at a time over valid/ready, grants round-robin, drives the ALU select and operands from registered copies, captures result and zero flag, and returns them on the winning port's response channel with backpressure.

## Interface
- WIDTH, 32, operand/result width; must match the ALU datapath width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  4  ALU select code
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  response present
- rsp0_ready / rsp1_ready  in  1  requester takes response
- rsp0_result / rsp1_result  out  WIDTH  captured ALU result
- rsp0_zero / rsp1_zero  out  1  captured equality flag (a == b)
- rsp0_err / rsp1_err  out  1  op code was 8..15 (unsupported)
- alu_ctrl  out  4  select to ALU
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_out  in  WIDTH  ALU result
- alu_zero  in  1  ALU equality flag

## Operation
- Op codes: 0 mov, 1 not, 2 add, 3 sub, 4 or, 5 and, 6 xor, 7 slt (signed); 8..15 yield result 0 from ALU and set err.
- FSM states IDLE, EXEC, RESP.
- IDLE: reqN_ready = 1 only for the port granted this cycle; grant is combinational from valids and last_grant. Only one valid -> that port. Both valid -> port != last_grant. On handshake latch op, a, b, port id; last_grant <= port; go EXEC.
- EXEC: alu_ctrl/alu_a/alu_b driven from latched registers; at cycle end capture alu_out, alu_zero, err = op[3]; go RESP.
- RESP: rspP_valid = 1 for latched port only; result/zero/err stable until rspP_ready. On handshake go IDLE. Both req ready = 0.
- alu_ctrl/alu_a/alu_b hold latched values in all states (no toggling outside EXEC-relevant change); never driven from unregistered requester inputs.
- Non-granted port's valid may stay high indefinitely; it wins the next IDLE arbitration (no starvation).
- Requester inputs may change freely after handshake; latched copy is used.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, last_grant = 1 (port 0 wins first tie), latched op/a/b = 0, all rsp*_valid/result/zero/err = 0, req*_ready = 0 while in reset, alu_ctrl = 0, alu_a = alu_b = 0.
- Latency: request handshake in cycle t -> EXEC in t+1 -> rsp_valid asserted in t+2.
- Max throughput one op per 3 cycles with rsp_ready held high; new request accepted no earlier than cycle after response handshake.
- rsp_ready low in RESP: stay in RESP, outputs frozen, requests not accepted.
- Reset mid-EXEC or mid-RESP: operation dropped, no response emitted, outputs return to reset values immediately.
- rsp_ready high outside RESP: ignored.

## Structure
- Shared package alu_pkg: WIDTH default, op-code localparams (OP_MOV..OP_SLT), state encoding for IDLE/EXEC/RESP.
- One sub-module: rr_arb2 (two valids + last_grant in, one-hot grant out, purely combinational).
- ALU instantiated outside; this block only drives/consumes its ports.

## Test plan
- Single add: port0 op=2, a=5, b=7, rsp0_ready=1 -> rsp0_valid 2 cycles after handshake, result=12, zero=0, err=0; port1 untouched.
- Simultaneous requests after reset: both valid, port0 op=3 a=10 b=10, port1 op=7 a=0xFFFFFFFF b=1 -> port0 served first (result 0, zero=1), then port1 (result 1), then if both re-valid port0 again.
- Backpressure: port1 op=6 a=0xF0F0 b=0x0FF0, rsp1_ready low 5 cycles -> rsp1_valid and result 0xFF00 held stable 5 cycles, req0_ready stays 0 though req0_valid high.
- Illegal op: port0 op=9 a=3 b=3 -> result 0, zero=1, err=1.
- Reset mid-op: assert reset_n=0 during EXEC -> no rsp*_valid ever for that op; after release a new port0 mov a=0x1234 returns 0x1234.
- Starvation: port0 valid continuously, port1 valid from cycle 2 -> grants strictly alternate 0,1,0,1 over 8 ops.
